// File: rtl/serial_to_parallel_loader_pkg.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_loader_pkg
// Shared definitions for the serial-to-parallel loader and the N-bit parallel
// register it feeds.
//   state_t   : FSM state encoding (IDLE = 0, SHIFT = 1, PARITY = 2)
//   DEFAULT_N : default data word width, shared with the downstream register
// -----------------------------------------------------------------------------
package serial_to_parallel_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_N = 5;

endpackage : serial_to_parallel_loader_pkg

// File: rtl/serial_to_parallel_loader_bit_counter.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_loader_bit_counter
// Mod-MODULUS up-counter with synchronous clear and count enable. The count
// wraps to 0 after MODULUS-1, so it never exceeds MODULUS-1.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (count -> 0)
//   i_clr  : synchronous clear (count -> 0)
//   i_en   : advance the count by one
//   o_tc   : terminal count, high while the count equals MODULUS-1
// -----------------------------------------------------------------------------
module serial_to_parallel_loader_bit_counter
    import serial_to_parallel_loader_pkg::*;
#(
    parameter int MODULUS = DEFAULT_N,
    parameter int WIDTH   = $clog2(MODULUS + 1)
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    // Count register: reset/clear to zero, wrap to zero after the last value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_en) begin
            if (r_count == LAST) begin
                r_count <= {WIDTH{1'b0}};
            end else begin
                r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == LAST);

endmodule : serial_to_parallel_loader_bit_counter

// File: rtl/serial_to_parallel_loader.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_loader
// Collects n serial bits after a Start request and presents them as a parallel
// word on Q, pulsing Q_valid for one cycle per completed word so the
// downstream register can use it directly as its load enable.
//
// Optional build macro: PARITY_CHECK_EN
//   When defined, one extra valid bit (even parity) follows the n data bits.
//   A good parity bit updates Q and pulses Q_valid; a bad one leaves Q
//   unchanged and pulses Err instead. Without it, Err is tied to 0.
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   Reset     : synchronous active-high reset, aborts any word in progress
//   Start     : begin a new word (honoured only in IDLE)
//   Sin       : serial data bit
//   Sin_valid : Sin carries a valid bit this cycle
//   Q         : last completed word (n bits)
//   Q_valid   : one-cycle pulse, Q updated this cycle
//   Busy      : high while a word is being collected
//   Err       : one-cycle parity-error pulse
// -----------------------------------------------------------------------------
module serial_to_parallel_loader
    import serial_to_parallel_loader_pkg::*;
#(
    parameter int n         = DEFAULT_N,
    parameter bit MSB_FIRST = 1'b1
)(
    input  logic         clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Sin,
    input  logic         Sin_valid,
    output logic [n-1:0] Q,
    output logic         Q_valid,
    output logic         Busy,
    output logic         Err
);

    localparam int CNT_W = $clog2(n + 1);

    state_t         r_state;
    logic [n-1:0]   r_shift;
    logic [n-1:0]   r_q;
    logic           r_q_valid;
    logic           r_busy;

    logic [n-1:0]   w_shift_next;
    logic           w_cnt_clr;
    logic           w_cnt_en;
    logic           w_tc;

`ifdef PARITY_CHECK_EN
    logic           r_err;

    // Even parity: data bits XOR parity bit must be zero.
    function automatic logic word_parity(input logic [n-1:0] d);
        return ^d;
    endfunction
`endif

    // Shift direction decides which end of Q the first received bit ends up in.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[n-2:0], Sin};
        end else begin : g_lsb_first
            assign w_shift_next = {Sin, r_shift[n-1:1]};
        end
    endgenerate

    assign w_cnt_clr = (r_state == ST_IDLE) && Start;
    assign w_cnt_en  = (r_state == ST_SHIFT) && Sin_valid;

    serial_to_parallel_loader_bit_counter #(
        .MODULUS (n),
        .WIDTH   (CNT_W)
    ) u_bit_counter (
        .i_clk (clk),
        .i_rst (Reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    // Control FSM with shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= {n{1'b0}};
            r_q       <= {n{1'b0}};
            r_q_valid <= 1'b0;
            r_busy    <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            // Pulses default low; only the completing edge raises them.
            r_q_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_err     <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // Sin is deliberately not sampled on the Start cycle.
                    if (Start) begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                        r_shift <= {n{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    if (Sin_valid) begin
                        r_shift <= w_shift_next;
                        // w_tc means this accepted bit is the nth one.
                        if (w_tc) begin
`ifdef PARITY_CHECK_EN
                            r_state   <= ST_PARITY;
`else
                            r_q       <= w_shift_next;
                            r_q_valid <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef PARITY_CHECK_EN
                ST_PARITY: begin
                    if (Sin_valid) begin
                        if ((word_parity(r_shift) ^ Sin) == 1'b0) begin
                            r_q       <= r_shift;
                            r_q_valid <= 1'b1;
                        end else begin
                            r_err     <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Q       = r_q;
    assign Q_valid = r_q_valid;
    assign Busy    = r_busy;
`ifdef PARITY_CHECK_EN
    assign Err     = r_err;
`else
    assign Err     = 1'b0;
`endif

endmodule : serial_to_parallel_loader

// File: tb/tb_serial_to_parallel_loader.sv
module tb_serial_to_parallel_loader;

    logic       clk;
    logic       Reset;
    logic       Start;
    logic       Sin;
    logic       Sin_valid;
    logic [4:0] q;
    logic       q_valid;
    logic       busy;
    logic       err;
    logic [4:0] q_l;
    logic       q_valid_l;
    logic       busy_l;
    logic       err_l;

    int tests;
    int fails;
    int qv_pulses;

    serial_to_parallel_loader #(.n(5), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Sin       (Sin),
        .Sin_valid (Sin_valid),
        .Q         (q),
        .Q_valid   (q_valid),
        .Busy      (busy),
        .Err       (err)
    );

    serial_to_parallel_loader #(.n(5), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Sin       (Sin),
        .Sin_valid (Sin_valid),
        .Q         (q_l),
        .Q_valid   (q_valid_l),
        .Busy      (busy_l),
        .Err       (err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count Q_valid pulses of the MSB-first instance away from the active edge.
    always @(negedge clk) begin
        if (q_valid === 1'b1) qv_pulses = qv_pulses + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the 5 data bits (bits[4] first) on consecutive valid cycles and,
    // with parity checking built in, one parity bit. Returns after the edge
    // that accepts the final bit.
    task automatic send_bits(input logic [4:0] bits, input logic bad_parity);
        for (int i = 4; i >= 0; i--) begin
            Sin = bits[i];
            Sin_valid = 1'b1;
            step();
        end
`ifdef PARITY_CHECK_EN
        Sin = (^bits) ^ bad_parity;
        Sin_valid = 1'b1;
        step();
`else
        if (bad_parity) Sin = 1'b0;
`endif
        Sin_valid = 1'b0;
        Sin = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b1; Sin = 1'b1; Sin_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            tests++; if (q !== 5'b00000) begin fails++; $display("FAIL reset_q cyc%0d: got %b want 00000", c, q); end
            tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL reset_qvalid cyc%0d: got %b want 0", c, q_valid); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy cyc%0d: got %b want 0", c, busy); end
            tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err cyc%0d: got %b want 0", c, err); end
        end
        Reset = 1'b0; Start = 1'b0; Sin = 1'b0; Sin_valid = 1'b0;
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_msb_first();
        Start = 1'b1;
        step();
        Start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL msb_busy_after_start: got %b want 1", busy); end
        send_bits(5'b10110, 1'b0);
        tests++; if (q !== 5'b10110) begin fails++; $display("FAIL msb_q: got %b want 10110", q); end
        tests++; if (q_valid !== 1'b1) begin fails++; $display("FAIL msb_qvalid: got %b want 1", q_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL msb_busy_fall: got %b want 0", busy); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL msb_err: got %b want 0", err); end
        tests++; if (q_l !== 5'b01101) begin fails++; $display("FAIL lsb_q: got %b want 01101", q_l); end
        step();
        tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL msb_qvalid_one_cycle: got %b want 0", q_valid); end
        tests++; if (q !== 5'b10110) begin fails++; $display("FAIL msb_q_hold: got %b want 10110", q); end
    endtask

    task automatic test_gaps();
        logic [4:0] bits;
        logic       early_bad;
        int         start_pulses;
        bits = 5'b10110;
        early_bad = 1'b0;
        start_pulses = qv_pulses;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (i != 4) begin
                for (int g = 0; g < 2; g++) begin
                    Sin = ~bits[i]; Sin_valid = 1'b0;
                    step();
                    if (busy !== 1'b1 || q_valid !== 1'b0) early_bad = 1'b1;
                end
            end
            Sin = bits[i]; Sin_valid = 1'b1;
            step();
            if (i != 0 && (busy !== 1'b1 || q_valid !== 1'b0)) early_bad = 1'b1;
        end
`ifdef PARITY_CHECK_EN
        for (int g = 0; g < 2; g++) begin
            Sin = 1'b0; Sin_valid = 1'b0;
            step();
            if (busy !== 1'b1 || q_valid !== 1'b0) early_bad = 1'b1;
        end
        Sin = ^bits; Sin_valid = 1'b1;
        step();
`endif
        Sin_valid = 1'b0; Sin = 1'b0;
        tests++; if (early_bad !== 1'b0) begin fails++; $display("FAIL gap_stall: early Q_valid or Busy drop seen=%b want 0", early_bad); end
        tests++; if (q_valid !== 1'b1) begin fails++; $display("FAIL gap_qvalid_timing: got %b want 1", q_valid); end
        tests++; if (q !== 5'b10110) begin fails++; $display("FAIL gap_q: got %b want 10110", q); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL gap_busy: got %b want 0", busy); end
        for (int c = 0; c < 3; c++) step();
        tests++; if (qv_pulses - start_pulses !== 1) begin fails++; $display("FAIL gap_pulse_count: got %0d want 1", qv_pulses - start_pulses); end
    endtask

    task automatic test_abort();
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Sin = 1'b1; Sin_valid = 1'b1;
            step();
        end
        Reset = 1'b1; Sin_valid = 1'b1;
        step();
        Reset = 1'b0; Sin_valid = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
        tests++; if (q !== 5'b00000) begin fails++; $display("FAIL abort_q_reset: got %b want 00000", q); end
        Start = 1'b1;
        step();
        Start = 1'b0;
        send_bits(5'b01110, 1'b0);
        tests++; if (q !== 5'b01110) begin fails++; $display("FAIL abort_new_q: got %b want 01110", q); end
        tests++; if (q_valid !== 1'b1) begin fails++; $display("FAIL abort_new_qvalid: got %b want 1", q_valid); end
        tests++; if (q_l !== 5'b01110) begin fails++; $display("FAIL abort_new_lsb_q: got %b want 01110", q_l); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0] bits;
        bits = 5'b11001;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
        Start = 1'b1;
        step();
        for (int i = 4; i >= 0; i--) begin
            Sin = bits[i]; Sin_valid = 1'b1;
            Start = (i == 3 || i == 1);
            step();
            if (i == 2) begin
                Start = 1'b1; Sin_valid = 1'b0;
                step();
            end
        end
        Start = 1'b0;
`ifdef PARITY_CHECK_EN
        Sin = ^bits; Sin_valid = 1'b1;
        step();
`endif
        Sin_valid = 1'b0; Sin = 1'b0;
        tests++; if (q_valid !== 1'b1) begin fails++; $display("FAIL b2b_first_qvalid: got %b want 1", q_valid); end
        tests++; if (q !== 5'b11001) begin fails++; $display("FAIL b2b_first_q: got %b want 11001", q); end
        // Start on the Q_valid cycle is accepted.
        Start = 1'b1;
        step();
        Start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_start_on_qvalid: busy got %b want 1", busy); end
        tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL b2b_qvalid_drop: got %b want 0", q_valid); end
        send_bits(5'b10101, 1'b0);
        tests++; if (q !== 5'b10101) begin fails++; $display("FAIL b2b_second_q: got %b want 10101", q); end
        tests++; if (q_valid !== 1'b1) begin fails++; $display("FAIL b2b_second_qvalid: got %b want 1", q_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_second_busy: got %b want 0", busy); end
        step();
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity_error();
        Start = 1'b1;
        step();
        Start = 1'b0;
        send_bits(5'b10110, 1'b1);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL parity_err: got %b want 1", err); end
        tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL parity_qvalid: got %b want 0", q_valid); end
        tests++; if (q !== 5'b10101) begin fails++; $display("FAIL parity_q_unchanged: got %b want 10101", q); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL parity_busy: got %b want 0", busy); end
        step();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL parity_err_one_cycle: got %b want 0", err); end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        qv_pulses = 0;
        Reset = 1'b1; Start = 1'b0; Sin = 1'b0; Sin_valid = 1'b0;
        test_reset();
        test_msb_first();
        test_gaps();
        test_abort();
        test_back_to_back();
`ifdef PARITY_CHECK_EN
        test_parity_error();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_to_parallel_loader

// File: doc/serial_to_parallel_loader.md
Name: serial_to_parallel_loader

Overview:
- Upstream feeder for the team's N-bit parallel register.
- Collects n serial bits under a start/valid handshake and assembles them into a parallel word on Q.
- Pulses Q_valid for one cycle per completed word, so the downstream register can use it as its load enable.
- Synchronous control only: one clock, a bit counter and a small FSM.

Parameters:
- n, 5, data word width in bits (n >= 2).
- MSB_FIRST, 1, 1 = first received bit lands in Q[n-1]; 0 = first bit lands in Q[0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin a new word; honoured only in IDLE.
- Sin  input  1  serial data bit.
- Sin_valid  input  1  Sin carries a valid bit this cycle.
- Q  output  n  assembled parallel word; holds the last completed word.
- Q_valid  output  1  one-cycle pulse: Q updated this cycle.
- Busy  output  1  high while a word is being collected.
- Err  output  1  one-cycle parity-error pulse; constant 0 unless PARITY_CHECK_EN.

Behaviour:
- Reset (synchronous, active-high):
  - Q = 0, Q_valid = 0, Busy = 0, Err = 0.
  - Bit count = 0, shift register = 0, state = IDLE.
  - Reset asserted mid-word aborts the word; partial bits are discarded.
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- IDLE:
  - Start = 1 -> SHIFT; Busy = 1 from the next cycle; count cleared.
  - Sin / Sin_valid are ignored, including on the Start cycle itself; the first data bit is sampled on the cycle after Start.
- SHIFT:
  - Each cycle with Sin_valid = 1 shifts Sin into the shift register and increments count.
  - Sin_valid = 0 stalls: no shift, count held, Busy stays 1.
  - Start is ignored while in SHIFT.
- Completion, on the edge that accepts bit n:
  - Q <= assembled word; Q_valid = 1 for exactly that following cycle.
  - Busy = 0 and state -> IDLE, all on the same edge.
  - Latency: Q/Q_valid are visible from the edge capturing the last bit.
- Back-to-back: Start asserted while Q_valid = 1 is accepted (state is already IDLE).
- Q holds its value between words; it never changes except on completion or Reset.
- Bit order:
  - MSB_FIRST = 1: bits 1,0,1,1,0 -> Q = 5'b10110.
  - MSB_FIRST = 0: the same bits -> Q = 5'b01101.
- Counter width is clog2(n+1); it wraps to 0 on completion, with no overflow past n.
- Simultaneous Reset and Start/Sin_valid: Reset wins.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- With the macro:
  - After n data bits, the FSM enters PARITY and waits for one more valid bit (even parity).
  - XOR of the data bits and the parity bit = 0 -> Q updated and Q_valid pulses.
  - Otherwise Q is unchanged, Err pulses for one cycle, and Q_valid stays 0.
  - Either way, state -> IDLE and Busy = 0.
- Without the macro:
  - No PARITY state; completion occurs after the nth data bit.
  - Err is tied to 0.

Decomposition:
- Shared package:
  - State encoding constants (IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2).
  - Default width constant DEFAULT_N = 5, shared with the N-bit register.
- One sub-module, bit_counter: parameterised mod-n up-counter with clear, enable and terminal-count output.
- Shift register, FSM and output registers stay in the top.

Test Plan:
- Reset held 2 cycles with Start = 1 and Sin_valid = 1 -> Q = 0, Q_valid = 0, Busy = 0 throughout.
- n = 5, MSB_FIRST = 1: Start, then bits 1,0,1,1,0 on consecutive valid cycles -> Q = 5'b10110, Q_valid high for 1 cycle, Busy falls on the same edge.
- Same bits with Sin_valid gaps of 2 cycles between bits -> identical Q, Q_valid delayed by the gap total; no extra Q_valid pulses.
- Reset after 3 bits, then a new word 0,1,1,1,0 -> Q = 5'b01110; the aborted bits leave no trace.
- Start asserted during SHIFT, and Start on the Q_valid cycle -> first ignored; second begins word 1,0,1,0,1 -> Q = 5'b10101.
- PARITY_CHECK_EN:
  - Data 10110 with parity 1 -> Q = 5'b10110, Q_valid pulses.
  - Parity 0 -> Err pulses, Q unchanged, no Q_valid.
